hk_bus_arbiter: RTL and testbench
=================================

HK_BUS_ARBITER -- requirements
Module: hk_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: cycles in WAIT without sys_ack before an error response (range 2..1023).
REQ-002 SHALL have ports clk_i (in, 1, clock) and rstn_i (in, 1, reset). One clock; reset is asynchronous and active-low.
REQ-003 SHALL have master A ports: ma_addr (in, 32), ma_wdata (in, 32), ma_wen (in, 1, write strobe), ma_ren (in, 1, read strobe), ma_rdata (out, 32), ma_err (out, 1), ma_ack (out, 1).
REQ-004 SHALL have master B ports mb_*, identical to master A.
REQ-005 SHALL have slave ports: sys_addr (out, 32), sys_wdata (out, 32), sys_wen (out, 1), sys_ren (out, 1), sys_rdata (in, 32), sys_err (in, 1), sys_ack (in, 1), connecting to the housekeeping register bus.

Function
REQ-006 SHALL treat a master wen/ren as a one-cycle strobe; in the strobe cycle it SHALL capture addr, wdata and type into that port's pending slot.
REQ-007 SHALL treat wen and ren high together as a write.
REQ-008 SHALL ignore a strobe on a port whose pending slot is occupied (no capture, no ack).
REQ-009 SHALL implement FSM states IDLE and WAIT.
REQ-010 In IDLE with at least one pending slot, SHALL grant one port, register its addr/wdata onto sys_*, and enter WAIT.
REQ-011 SHALL assert sys_wen or sys_ren for exactly the first WAIT cycle.
REQ-012 SHALL hold sys_addr and sys_wdata stable for all of WAIT.
REQ-013 Arbitration SHALL be round-robin: with both slots pending, grant the port not granted last; with one pending, grant it.
REQ-014 Minimum latency: master strobe in cycle 0 -> sys strobe in cycle 2.
REQ-015 In WAIT, sys_ack in cycle k SHALL produce owner ack=1 in cycle k+1 for one cycle, with rdata=sys_rdata (reads; 0 for writes) and err=sys_err; pending slot cleared; return to IDLE.
REQ-016 SHALL count WAIT cycles from the strobe cycle; if TIMEOUT cycles pass without sys_ack, the owner SHALL get ack=1, err=1, rdata=0 for one cycle, slot cleared, return to IDLE.
REQ-017 SHALL ignore sys_ack arriving in IDLE (late ack after timeout).
REQ-018 A strobe on the owner port arriving in the same cycle as its ack SHALL be captured.
REQ-019 The non-owner master SHALL see ack=0 whenever the other port is served.
REQ-020 Master ack/err/rdata and sys strobes SHALL be registered outputs.

Reset
REQ-021 On rstn_i low, SHALL clear immediately: state=IDLE, both pending slots empty, all outputs 0, timeout counter 0, last-grant=B (A wins the first tie).
REQ-022 Reset mid-WAIT SHALL drop the outstanding transaction with no ack to any master.

Structure
REQ-023 Package hk_bus_pkg SHALL hold the FSM state encoding, the port-ID constants (PORT_A, PORT_B) and the TIMEOUT default.
REQ-024 Sub-module hk_bus_req_slot SHALL implement the per-port capture/pending register and be instantiated twice.

Verification
REQ-025 A reads 0x00000 alone, slave acks 1 cycle after strobe -> sys_ren in cycle 2, ma_ack in cycle 4 with ma_rdata=0x00000001, ma_err=0.
REQ-026 A writes 0x30 (0x55) and B reads 0x30 in the same cycle -> A served first, then B; mb_rdata=0x00000055; the next tie is granted to A.
REQ-027 B reads with the slave silent, TIMEOUT=8 -> mb_ack=1, mb_err=1, mb_rdata=0 after 8 WAIT cycles; a slave ack injected 2 cycles later is ignored.
REQ-028 A strobes twice before its ack -> one sys transaction and one ma_ack only.
REQ-029 rstn_i asserted in cycle 3 of WAIT -> all outputs 0 asynchronously; no ack after release; a new request is served normally.
REQ-030 Write with wen and ren both high to 0x0C (data 1) -> sys_wen=1, sys_ren=0; ma_rdata=0.

Source files
------------

// File: rtl/hk_bus_pkg.sv
// Shared types and constants for the housekeeping bus arbiter.
package hk_bus_pkg;

  typedef enum logic {StIdle, StWait} hk_state_e;

  typedef logic hk_port_t;
  localparam hk_port_t PORT_A = 1'b0;
  localparam hk_port_t PORT_B = 1'b1;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  // Wide enough for the largest supported TIMEOUT (1023).
  localparam int unsigned CNT_W = 10;

endpackage

// File: rtl/hk_bus_req_slot.sv
// Per-master pending slot: captures one strobed request and holds it until served.
module hk_bus_req_slot (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        wen,
  input  logic        ren,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        clear,
  output logic        pending,
  output logic        is_write,
  output logic [31:0] slot_addr,
  output logic [31:0] slot_wdata
);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending    <= 1'b0;
      is_write   <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else if (clear) begin
      pending <= 1'b0;
    end else if ((wen || ren) && !pending) begin
      // wen wins when both strobes are high
      pending    <= 1'b1;
      is_write   <= wen;
      slot_addr  <= addr;
      slot_wdata <= wdata;
    end
  end

endmodule

// File: rtl/hk_bus_arbiter.sv
// Two-master round-robin arbiter onto the housekeeping register bus, with ack timeout.
module hk_bus_arbiter import hk_bus_pkg::*; #(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  input  logic        ma_wen,
  input  logic        ma_ren,
  output logic [31:0] ma_rdata,
  output logic        ma_err,
  output logic        ma_ack,
  input  logic [31:0] mb_addr,
  input  logic [31:0] mb_wdata,
  input  logic        mb_wen,
  input  logic        mb_ren,
  output logic [31:0] mb_rdata,
  output logic        mb_err,
  output logic        mb_ack,
  output logic [31:0] sys_addr,
  output logic [31:0] sys_wdata,
  output logic        sys_wen,
  output logic        sys_ren,
  input  logic [31:0] sys_rdata,
  input  logic        sys_err,
  input  logic        sys_ack
);

  logic        a_pend, a_write, b_pend, b_write, clr_a, clr_b;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;

  hk_bus_req_slot u_slot_a (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wen        (ma_wen),
    .ren        (ma_ren),
    .addr       (ma_addr),
    .wdata      (ma_wdata),
    .clear      (clr_a),
    .pending    (a_pend),
    .is_write   (a_write),
    .slot_addr  (a_addr),
    .slot_wdata (a_wdata)
  );

  hk_bus_req_slot u_slot_b (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .wen        (mb_wen),
    .ren        (mb_ren),
    .addr       (mb_addr),
    .wdata      (mb_wdata),
    .clear      (clr_b),
    .pending    (b_pend),
    .is_write   (b_write),
    .slot_addr  (b_addr),
    .slot_wdata (b_wdata)
  );

  hk_state_e        state_q, state_d;
  hk_port_t         owner_q, owner_d, last_q, last_d, grant;
  logic             is_write_q, is_write_d, done, err;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sys_addr_q, sys_addr_d, sys_wdata_q, sys_wdata_d, rdata;
  logic             sys_wen_q, sys_wen_d, sys_ren_q, sys_ren_d;
  logic             ma_ack_q, ma_ack_d, ma_err_q, ma_err_d;
  logic             mb_ack_q, mb_ack_d, mb_err_q, mb_err_d;
  logic [31:0]      ma_rdata_q, ma_rdata_d, mb_rdata_q, mb_rdata_d;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    sys_addr_d  = sys_addr_q;
    sys_wdata_d = sys_wdata_q;
    sys_wen_d   = 1'b0;
    sys_ren_d   = 1'b0;
    ma_ack_d    = 1'b0;
    ma_err_d    = 1'b0;
    ma_rdata_d  = '0;
    mb_ack_d    = 1'b0;
    mb_err_d    = 1'b0;
    mb_rdata_d  = '0;
    clr_a       = 1'b0;
    clr_b       = 1'b0;
    grant       = PORT_A;
    done        = 1'b0;
    err         = 1'b0;
    rdata       = '0;

    unique case (state_q)
      StIdle: begin
        if (a_pend || b_pend) begin
          grant       = (a_pend && (!b_pend || last_q == PORT_B)) ? PORT_A : PORT_B;
          owner_d     = grant;
          last_d      = grant;
          is_write_d  = (grant == PORT_A) ? a_write : b_write;
          sys_addr_d  = (grant == PORT_A) ? a_addr : b_addr;
          sys_wdata_d = (grant == PORT_A) ? a_wdata : b_wdata;
          sys_wen_d   = is_write_d;
          sys_ren_d   = !is_write_d;
          cnt_d       = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // A real ack in the final counted cycle still beats the timeout.
        if (sys_ack) begin
          done  = 1'b1;
          err   = sys_err;
          rdata = is_write_q ? 32'h0 : sys_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          done = 1'b1;
          err  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (owner_q == PORT_A) begin
            ma_ack_d   = 1'b1;
            ma_err_d   = err;
            ma_rdata_d = rdata;
            clr_a      = 1'b1;
          end else begin
            mb_ack_d   = 1'b1;
            mb_err_d   = err;
            mb_rdata_d = rdata;
            clr_b      = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      owner_q     <= PORT_A;
      last_q      <= PORT_B;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      sys_addr_q  <= '0;
      sys_wdata_q <= '0;
      sys_wen_q   <= 1'b0;
      sys_ren_q   <= 1'b0;
      ma_ack_q    <= 1'b0;
      ma_err_q    <= 1'b0;
      ma_rdata_q  <= '0;
      mb_ack_q    <= 1'b0;
      mb_err_q    <= 1'b0;
      mb_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      sys_addr_q  <= sys_addr_d;
      sys_wdata_q <= sys_wdata_d;
      sys_wen_q   <= sys_wen_d;
      sys_ren_q   <= sys_ren_d;
      ma_ack_q    <= ma_ack_d;
      ma_err_q    <= ma_err_d;
      ma_rdata_q  <= ma_rdata_d;
      mb_ack_q    <= mb_ack_d;
      mb_err_q    <= mb_err_d;
      mb_rdata_q  <= mb_rdata_d;
    end
  end

  assign sys_addr  = sys_addr_q;
  assign sys_wdata = sys_wdata_q;
  assign sys_wen   = sys_wen_q;
  assign sys_ren   = sys_ren_q;
  assign ma_ack    = ma_ack_q;
  assign ma_err    = ma_err_q;
  assign ma_rdata  = ma_rdata_q;
  assign mb_ack    = mb_ack_q;
  assign mb_err    = mb_err_q;
  assign mb_rdata  = mb_rdata_q;

endmodule

// File: tb/tb_hk_bus_arbiter.sv
// Directed bench for hk_bus_arbiter; cycle 0 is the cycle a master strobe is driven.
module tb_hk_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [31:0] ma_addr, ma_wdata, ma_rdata, mb_addr, mb_wdata, mb_rdata;
  logic        ma_wen, ma_ren, ma_err, ma_ack, mb_wen, mb_ren, mb_err, mb_ack;
  logic [31:0] sys_addr, sys_wdata, sys_rdata;
  logic        sys_wen, sys_ren, sys_err, sys_ack;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 clk_i = ~clk_i;

  hk_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .ma_addr   (ma_addr),
    .ma_wdata  (ma_wdata),
    .ma_wen    (ma_wen),
    .ma_ren    (ma_ren),
    .ma_rdata  (ma_rdata),
    .ma_err    (ma_err),
    .ma_ack    (ma_ack),
    .mb_addr   (mb_addr),
    .mb_wdata  (mb_wdata),
    .mb_wen    (mb_wen),
    .mb_ren    (mb_ren),
    .mb_rdata  (mb_rdata),
    .mb_err    (mb_err),
    .mb_ack    (mb_ack),
    .sys_addr  (sys_addr),
    .sys_wdata (sys_wdata),
    .sys_wen   (sys_wen),
    .sys_ren   (sys_ren),
    .sys_rdata (sys_rdata),
    .sys_err   (sys_err),
    .sys_ack   (sys_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle; strobes and slave response are single-cycle by default.
  task automatic tick();
    @(posedge clk_i);
    #1;
    ma_wen  = 1'b0;
    ma_ren  = 1'b0;
    mb_wen  = 1'b0;
    mb_ren  = 1'b0;
    sys_ack = 1'b0;
    sys_err = 1'b0;
  endtask

  task automatic do_reset();
    rstn_i    = 1'b0;
    ma_addr   = '0;
    ma_wdata  = '0;
    mb_addr   = '0;
    mb_wdata  = '0;
    sys_rdata = '0;
    ma_wen = 1'b0; ma_ren = 1'b0; mb_wen = 1'b0; mb_ren = 1'b0;
    sys_ack = 1'b0; sys_err = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    // Single read by A, slave acks one cycle after the sys strobe
    do_reset();
    check("rst_flags", {30'd0, ma_ack, ma_err}, 32'h0);
    check("rst_flags_b", {30'd0, mb_ack, mb_err}, 32'h0);
    check("rst_sys_strobes", {30'd0, sys_wen, sys_ren}, 32'h0);
    check("rst_sys_addr", sys_addr, 32'h0);
    check("rst_rdata", ma_rdata | mb_rdata, 32'h0);
    ma_addr = 32'h0; ma_ren = 1'b1;
    tick();
    check("t1_c1_no_strobe", sys_ren, 1'b0);
    tick();
    check("t1_c2_sys_ren", sys_ren, 1'b1);
    check("t1_c2_sys_wen", sys_wen, 1'b0);
    check("t1_c2_sys_addr", sys_addr, 32'h0);
    tick();
    check("t1_c3_ren_one_cycle", sys_ren, 1'b0);
    check("t1_c3_no_ack_yet", ma_ack, 1'b0);
    sys_ack = 1'b1; sys_rdata = 32'h1;
    tick();
    check("t1_c4_ma_ack", ma_ack, 1'b1);
    check("t1_c4_ma_rdata", ma_rdata, 32'h1);
    check("t1_c4_ma_err", ma_err, 1'b0);
    check("t1_c4_mb_ack", mb_ack, 1'b0);
    // Strobe in the owner's ack cycle must be taken
    ma_ren = 1'b1; ma_addr = 32'h20;
    tick();
    check("t1_c5_ack_single", ma_ack, 1'b0);
    tick();
    check("t1_c6_recapture_ren", sys_ren, 1'b1);
    check("t1_c6_recapture_addr", sys_addr, 32'h20);
    sys_ack = 1'b1; sys_rdata = 32'h1234;
    tick();
    check("t1_c7_ack2", ma_ack, 1'b1);
    check("t1_c7_rdata2", ma_rdata, 32'h1234);

    // Simultaneous A write and B read, then a second tie
    do_reset();
    ma_wen = 1'b1; ma_addr = 32'h30; ma_wdata = 32'h55;
    mb_ren = 1'b1; mb_addr = 32'h30;
    tick();
    tick();
    check("t2_a_first_wen", sys_wen, 1'b1);
    check("t2_a_first_ren", sys_ren, 1'b0);
    check("t2_a_addr", sys_addr, 32'h30);
    check("t2_a_wdata", sys_wdata, 32'h55);
    sys_ack = 1'b1; sys_rdata = 32'hABCD;
    tick();
    check("t2_ma_ack", ma_ack, 1'b1);
    check("t2_ma_rdata_write", ma_rdata, 32'h0);
    check("t2_mb_idle", mb_ack, 1'b0);
    tick();
    check("t2_b_ren", sys_ren, 1'b1);
    check("t2_b_addr", sys_addr, 32'h30);
    sys_ack = 1'b1; sys_rdata = 32'h55;
    tick();
    check("t2_mb_ack", mb_ack, 1'b1);
    check("t2_mb_rdata", mb_rdata, 32'h55);
    check("t2_ma_quiet", ma_ack, 1'b0);
    ma_ren = 1'b1; ma_addr = 32'h4;
    mb_ren = 1'b1; mb_addr = 32'h8;
    tick();
    tick();
    check("t2_tie_to_a", sys_addr, 32'h4);
    sys_ack = 1'b1;
    tick();
    check("t2_tie_ma_ack", ma_ack, 1'b1);
    tick();
    check("t2_then_b", sys_addr, 32'h8);
    sys_ack = 1'b1;
    tick();
    check("t2_then_mb_ack", mb_ack, 1'b1);

    // B read with a silent slave times out after 8 WAIT cycles
    do_reset();
    mb_ren = 1'b1; mb_addr = 32'h40; sys_rdata = 32'hDEADBEEF;
    tick();
    tick();
    check("t3_sys_ren", sys_ren, 1'b1);
    cnt = 0;
    repeat (7) begin
      tick();
      cnt += int'(mb_ack) + int'(ma_ack);
    end
    check("t3_no_early_ack", cnt, 0);
    check("t3_addr_stable", sys_addr, 32'h40);
    tick();
    check("t3_to_ack", mb_ack, 1'b1);
    check("t3_to_err", mb_err, 1'b1);
    check("t3_to_rdata", mb_rdata, 32'h0);
    tick();
    check("t3_ack_one_cycle", mb_ack, 1'b0);
    tick();
    sys_ack = 1'b1; sys_err = 1'b1;
    tick();
    check("t3_late_ack_ignored", {30'd0, mb_ack, mb_err}, 32'h0);
    tick();
    check("t3_late_no_strobe", {30'd0, ma_ack, sys_ren}, 32'h0);

    // Second strobe while pending is dropped
    do_reset();
    ma_ren = 1'b1; ma_addr = 32'h10;
    tick();
    tick();
    check("t4_sys_ren", sys_ren, 1'b1);
    ma_ren = 1'b1;
    tick();
    sys_ack = 1'b1; sys_rdata = 32'h7;
    tick();
    check("t4_ma_ack", ma_ack, 1'b1);
    check("t4_ma_rdata", ma_rdata, 32'h7);
    cnt = 0;
    repeat (8) begin
      tick();
      cnt += int'(sys_ren) + int'(sys_wen) + int'(ma_ack);
    end
    check("t4_single_txn", cnt, 0);

    // Reset in the third WAIT cycle drops the transaction
    do_reset();
    ma_wen = 1'b1; ma_addr = 32'h50; ma_wdata = 32'hAA;
    repeat (4) tick();
    check("t5_pre_reset_addr", sys_addr, 32'h50);
    #1 rstn_i = 1'b0;
    #1;
    check("t5_async_addr", sys_addr, 32'h0);
    check("t5_async_wdata", sys_wdata, 32'h0);
    check("t5_async_flags",
          {26'd0, ma_ack, ma_err, mb_ack, mb_err, sys_wen, sys_ren}, 32'h0);
    repeat (2) tick();
    rstn_i = 1'b1;
    sys_ack = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick();
      cnt += int'(ma_ack) + int'(mb_ack) + int'(sys_ren) + int'(sys_wen);
    end
    check("t5_no_ack_after_reset", cnt, 0);
    mb_ren = 1'b1; mb_addr = 32'h60;
    tick();
    tick();
    check("t5_new_ren", sys_ren, 1'b1);
    check("t5_new_addr", sys_addr, 32'h60);
    sys_ack = 1'b1; sys_rdata = 32'h66;
    tick();
    check("t5_new_ack", mb_ack, 1'b1);
    check("t5_new_rdata", mb_rdata, 32'h66);

    // wen and ren together are a write
    do_reset();
    ma_wen = 1'b1; ma_ren = 1'b1; ma_addr = 32'h0C; ma_wdata = 32'h1;
    tick();
    tick();
    check("t6_wen", sys_wen, 1'b1);
    check("t6_ren", sys_ren, 1'b0);
    check("t6_addr", sys_addr, 32'h0C);
    check("t6_wdata", sys_wdata, 32'h1);
    sys_ack = 1'b1; sys_rdata = 32'hFFFFFFFF;
    tick();
    check("t6_ack", ma_ack, 1'b1);
    check("t6_rdata_zero", ma_rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
